// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32
) ();
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: round-robin
// grant, range check, one memory command per transaction and a one-cycle ack.
module dmem_arbiter #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned AW        = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  dmem_arbiter_if.slave  bus
);

  localparam logic [AW-1:0] DEPTH_C = AW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        state_r;
  logic          gnt_r;
  logic          last_gnt_r;
  logic          we_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          err0_r;
  logic          err1_r;
  logic [31:0]   rdata0_r;
  logic [31:0]   rdata1_r;
  logic          mem_rd_r;
  logic          mem_wr_r;
  logic [AW-1:0] mem_addr_r;
  logic [31:0]   mem_din_r;

  logic          pick_vld_s;
  logic          pick_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic          in_range_s;

  // Winner selection: a lone requester wins, contention goes to the one not granted last.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick_vld_s = 1'b1;
      pick_s     = ~last_gnt_r;
    end else if (bus.req0) begin
      pick_vld_s = 1'b1;
      pick_s     = 1'b0;
    end else if (bus.req1) begin
      pick_vld_s = 1'b1;
      pick_s     = 1'b1;
    end else begin
      pick_vld_s = 1'b0;
      pick_s     = 1'b0;
    end
    sel_we_s    = pick_s ? bus.we1    : bus.we0;
    sel_addr_s  = pick_s ? bus.addr1  : bus.addr0;
    sel_wdata_s = pick_s ? bus.wdata1 : bus.wdata0;
    in_range_s  = (sel_addr_s < DEPTH_C);
  end

  // Sequencer FSM; every output is a register written only here.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= IDLE;
      gnt_r      <= 1'b0;
      last_gnt_r <= 1'b1;
      we_r       <= 1'b0;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
      rdata0_r   <= 32'd0;
      rdata1_r   <= 32'd0;
      mem_rd_r   <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_vld_s) begin
            gnt_r      <= pick_s;
            last_gnt_r <= pick_s;
            we_r       <= sel_we_s;
            if (in_range_s) begin
              mem_addr_r <= sel_addr_s;
              mem_din_r  <= sel_wdata_s;
              mem_rd_r   <= ~sel_we_s;
              mem_wr_r   <= sel_we_s;
              state_r    <= ISSUE;
            end else begin
              // Out of range: answer immediately, memory untouched.
              if (pick_s) begin
                ack1_r <= 1'b1;
                err1_r <= 1'b1;
              end else begin
                ack0_r <= 1'b1;
                err0_r <= 1'b1;
              end
              state_r <= ACK;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
          state_r  <= CAPT;
        end
        CAPT: begin
          if (gnt_r) begin
            ack1_r   <= 1'b1;
            rdata1_r <= we_r ? 32'd0 : bus.mem_dout;
          end else begin
            ack0_r   <= 1'b1;
            rdata0_r <= we_r ? 32'd0 : bus.mem_dout;
          end
          state_r <= ACK;
        end
        ACK: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          err0_r   <= 1'b0;
          err1_r   <= 1'b0;
          rdata0_r <= 32'd0;
          rdata1_r <= 32'd0;
          state_r  <= IDLE;
        end
        default: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          err0_r   <= 1'b0;
          err1_r   <= 1'b0;
          rdata0_r <= 32'd0;
          rdata1_r <= 32'd0;
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0     = ack0_r;
  assign bus.ack1     = ack1_r;
  assign bus.err0     = err0_r;
  assign bus.err1     = err1_r;
  assign bus.rdata0   = rdata0_r;
  assign bus.rdata1   = rdata1_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.mem_wr   = mem_wr_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_din  = mem_din_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (32-bit words, 4096 deep).
- The memory has a registered read and a registered write on the clock edge; rd and wr must never be high together.
- Requester 0 is the CPU load/store stage and requester 1 is the DMA/debug port.
- This block serialises both onto the memory, guarantees rd/wr exclusivity, range-checks addresses and returns read data with a one-cycle ack.

Parameters:
- MEM_DEPTH, 4096, number of memory words; addresses >= MEM_DEPTH are out of range.
- AW, 32, address width of requester and memory ports.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  synchronous, active-low reset, sampled on posedge CLK.
- req0 / req1  input  1  request, level; held with we/addr/wdata stable until ack.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  AW  word address.
- wdata0 / wdata1  input  32  write data.
- ack0 / ack1  output  1  one-cycle completion pulse (registered).
- err0 / err1  output  1  valid with ack; 1 = address out of range, no memory access performed.
- rdata0 / rdata1  output  32  read data, valid while ack is high (registered).
- mem_rd  output  1  to memory rd (registered).
- mem_wr  output  1  to memory wr (registered).
- mem_addr  output  AW  to memory add_lines (registered).
- mem_din  output  32  to memory d_in (registered).
- mem_dout  input  32  from memory d_out; valid the cycle after mem_rd is sampled.

Behaviour:
- Reset (RST_N=0 at posedge):
  - All outputs go to 0 and the state goes to IDLE.
  - last_gnt=1, so requester 0 wins the first contention.
- States and transitions:
  - IDLE: if no req, stay. Otherwise pick the winner:
    - only one requester asserts req: it wins;
    - both assert req: the requester != last_gnt wins.
  - IDLE, on a pick: latch gnt and update last_gnt.
    - Address in range: load mem_addr and mem_din, set mem_rd=!we or mem_wr=we, go to ISSUE.
    - Address >= MEM_DEPTH: set err, go to ACK with rdata=0. mem_rd and mem_wr stay 0.
  - ISSUE: memory command visible for exactly this cycle. At the next edge mem_rd and mem_wr clear, and the memory performs the access; go to CAPT.
  - CAPT:
    - Read: at the edge, capture mem_dout into rdata[gnt].
    - Write: rdata[gnt] is set to 0.
    - Go to ACK, with ack[gnt]=1 registered into the ACK cycle.
  - ACK: ack[gnt]=1 for exactly this cycle; req is ignored. Next edge clears ack, err and rdata; go to IDLE.
- Latency and throughput:
  - Request sampled in cycle T0 gives mem_rd or mem_wr high in T1 and ack in T3.
  - Error path: ack in T1.
  - One access per 4 cycles maximum.
- Handshake:
  - The requester deasserts req in the cycle after ack, or keeps it high to issue a new request.
  - req seen in IDLE is always treated as a new request.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Invariants:
  - mem_rd & mem_wr is never 1.
  - ack0 & ack1 is never 1.
  - rdata and err are 0 whenever the corresponding ack is 0.
- Address compare: addr < MEM_DEPTH, unsigned, over the full AW bits. mem_addr carries the full address.
- Reset mid-operation:
  - Pending transaction is dropped and no ack is issued.
  - If reset is sampled at the end of ISSUE, the memory still samples mem_wr/mem_rd at that edge, so the write takes effect. Not reported.
- Requests arriving while busy: held by the requester, arbitrated at the next IDLE.

Test Plan:
- Reset then single write: req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF at T0 -> mem_wr=1, mem_addr=0x10 in T1 only; ack0=1, err0=0, rdata0=0 in T3.
- Read-back: req1, we1=0, addr1=0x10 -> mem_rd=1 in T1; ack1 with rdata1=0xDEADBEEF in T3; ack0 stays 0.
- Contention from reset: req0 and req1 held high with distinct addresses -> grant order 0,1,0,1 over 4 transactions; acks 4 cycles apart; mem_rd&mem_wr never 1.
- Out of range: req0, addr0=4096 -> ack0=1, err0=1, rdata0=0 in T1; mem_rd and mem_wr stay 0; memory contents unchanged.
- Reset in CAPT of a read: RST_N=0 for 1 cycle -> no ack; all outputs 0; next req1 read of 0x10 still returns 0xDEADBEEF.
- Back-to-back single requester: req0 held high across ack with new addr/we after ack -> second mem access in cycle T5, ack at T7.
